// File: rtl/axi_read_arbiter_pkg.sv
// Shared constants and types for the AXI read-channel arbiter: AXI ids,
// fixed AR encodings, FSM state and grant encodings.
package axi_read_arbiter_pkg;

  localparam int CACHELINE_WIDTH = 512;
  localparam int DEF_LINE_WORDS  = CACHELINE_WIDTH / 32;

  localparam logic [3:0] ID_ICACHE  = 4'd0;
  localparam logic [3:0] ID_DCACHE  = 4'd1;
  localparam logic [3:0] ID_UNCACHE = 4'd2;

  localparam logic [2:0] ARSIZE_WORD = 3'b010;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_DONE,
    ST_GAP
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_ICACHE,
    GNT_DCACHE,
    GNT_UNCACHE
  } grant_e;

endpackage

// File: rtl/axi_rd_line_buf.sv
// Beat counter plus word-indexed line register that collects R beats.
// The counter saturates on the last word so surplus beats overwrite it.
module axi_rd_line_buf #(
  parameter int LINE_WORDS = 16,
  parameter int CNT_W      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [31:0]              wr_data,
  output logic [LINE_WORDS*32-1:0] line
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (wr_en && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Clearing the counter leaves the words alone: a short burst keeps stale data.
  generate
    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_word
      logic [31:0] word_q, word_d;

      always_comb begin
        word_d = word_q;
        if (wr_en && (cnt_q == CNT_W'(gi))) begin
          word_d = wr_data;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          word_q <= '0;
        end else begin
          word_q <= word_d;
        end
      end

      assign line[gi*32 +: 32] = word_q;
    end
  endgenerate

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read channel between icache refill, dcache refill and
// uncached loads; one transaction at a time, result pulsed via refresh.
module axi_read_arbiter
  import axi_read_arbiter_pkg::*;
#(
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int LINE_WIDTH = LINE_WORDS * 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icache_ren,
  input  logic [31:0]           icache_raddr,
  output logic [LINE_WIDTH-1:0] icache_line,
  output logic                  icache_refresh,
  input  logic                  dcache_ren,
  input  logic [31:0]           dcache_raddr,
  output logic [LINE_WIDTH-1:0] dcache_line,
  output logic                  dcache_refresh,
  input  logic                  uncache_ren,
  input  logic [31:0]           uncache_raddr,
  output logic [31:0]           uncache_rdata,
  output logic                  uncache_refresh,
  output logic [3:0]            arid,
  output logic [31:0]           araddr,
  output logic [3:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [3:0]            rid,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic                  stallreq
);

  localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);
  localparam logic [3:0]  LINE_LEN  = 4'(LINE_WORDS - 1);

  state_e      state_q, state_d;
  grant_e      grant_q, grant_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  id_q, id_d;
  logic        buf_clr, buf_wr;
  logic [LINE_WIDTH-1:0] line;

  // Only one transaction is ever outstanding, so rid and rresp carry nothing we need.
  logic unused_r_fields;
  assign unused_r_fields = ^{rid, rresp};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= GNT_NONE;
      addr_q  <= '0;
      len_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    len_d   = len_q;
    id_d    = id_q;
    buf_clr = 1'b0;
    buf_wr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (uncache_ren) begin
          grant_d = GNT_UNCACHE;
          addr_d  = uncache_raddr;
          len_d   = 4'd0;
          id_d    = ID_UNCACHE;
          state_d = ST_AR;
        end else if (dcache_ren) begin
          grant_d = GNT_DCACHE;
          addr_d  = dcache_raddr & LINE_MASK;
          len_d   = LINE_LEN;
          id_d    = ID_DCACHE;
          state_d = ST_AR;
        end else if (icache_ren) begin
          grant_d = GNT_ICACHE;
          addr_d  = icache_raddr & LINE_MASK;
          len_d   = LINE_LEN;
          id_d    = ID_ICACHE;
          state_d = ST_AR;
        end
      end
      ST_AR: begin
        if (arready) begin
          buf_clr = 1'b1;
          state_d = ST_R;
        end
      end
      ST_R: begin
        if (rvalid) begin
          buf_wr = 1'b1;
          if (rlast) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_GAP;
      // Dead cycle lets the served requester drop ren before re-arbitration.
      ST_GAP: begin
        grant_d = GNT_NONE;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  axi_rd_line_buf #(
    .LINE_WORDS(LINE_WORDS)
  ) u_line_buf (
    .clk    (clk),
    .rst    (rst),
    .clr    (buf_clr),
    .wr_en  (buf_wr),
    .wr_data(rdata),
    .line   (line)
  );

  assign arid    = id_q;
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = ARSIZE_WORD;
  assign arburst = BURST_INCR;
  assign arvalid = (state_q == ST_AR);
  assign rready  = (state_q == ST_R);

  assign icache_refresh  = (state_q == ST_DONE) && (grant_q == GNT_ICACHE);
  assign dcache_refresh  = (state_q == ST_DONE) && (grant_q == GNT_DCACHE);
  assign uncache_refresh = (state_q == ST_DONE) && (grant_q == GNT_UNCACHE);

  assign icache_line   = line;
  assign dcache_line   = line;
  assign uncache_rdata = line[31:0];

  assign stallreq = (state_q != ST_IDLE) | icache_ren | dcache_ren | uncache_ren;

endmodule
